// File: rtl/key_search_ctrl.sv
// Key search controller: walks KEY_START..KEY_END, launching one decrypt attempt per key
// and stopping on the first key whose plaintext is reported valid.
module key_search_ctrl #(
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_END   = 24'h3FFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic        attempt_done,
  input  logic        attempt_valid,
  output logic [23:0] key_out,
  output logic        attempt_start,
  output logic        busy,
  output logic        found,
  output logic        exhausted,
  output logic [23:0] found_key,
  output logic [24:0] attempts,
  output logic [3:0]  hex0,
  output logic [3:0]  hex1,
  output logic [3:0]  hex2,
  output logic [3:0]  hex3,
  output logic [3:0]  hex4,
  output logic [3:0]  hex5,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StLaunch    = 3'd1,
    StWait      = 3'd2,
    StFound     = 3'd3,
    StExhausted = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [23:0] key_q, key_d;
  logic [23:0] found_key_q, found_key_d;
  logic [24:0] attempts_q, attempts_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      key_q       <= KEY_START;
      found_key_q <= '0;
      attempts_q  <= '0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      found_key_q <= found_key_d;
      attempts_q  <= attempts_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    found_key_d = found_key_q;
    attempts_d  = attempts_q;
    // Abort returns to idle but keeps the key, count and result for inspection.
    if (abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle, StFound, StExhausted: begin
          if (start) begin
            state_d     = StLaunch;
            key_d       = KEY_START;
            found_key_d = '0;
            attempts_d  = '0;
          end
        end
        StLaunch: state_d = StWait;
        StWait: begin
          if (attempt_done) begin
            attempts_d = attempts_q + 25'd1;
            if (attempt_valid) begin
              found_key_d = key_q;
              state_d     = StFound;
            end else if (key_q == KEY_END) begin
              state_d = StExhausted;
            end else begin
              key_d   = key_q + 24'd1;
              state_d = StLaunch;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Status is forced low while reset is held so a mid-search reset emits no further pulse.
  always_comb begin
    attempt_start = (state_q == StLaunch) && !reset;
    busy          = ((state_q == StLaunch) || (state_q == StWait)) && !reset;
    found         = (state_q == StFound) && !reset;
    exhausted     = (state_q == StExhausted) && !reset;
  end

  assign key_out   = key_q;
  assign found_key = found_key_q;
  assign attempts  = attempts_q;
  assign state     = state_q;
  assign hex0      = key_q[3:0];
  assign hex1      = key_q[7:4];
  assign hex2      = key_q[11:8];
  assign hex3      = key_q[15:12];
  assign hex4      = key_q[19:16];
  assign hex5      = key_q[23:20];

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: four instances with different key ranges, each driven by a
// behavioural decrypt-engine model, checked against an arithmetic search model.
module tb_key_search_ctrl;

  // Packed index 0 is the rightmost element: dut0 0..5, dut1 0..2, dut2 ABCD, dut3 default.
  localparam logic [3:0][23:0] KS = {24'h000000, 24'h00ABCD, 24'h000000, 24'h000000};
  localparam logic [3:0][23:0] KE = {24'h3FFFFF, 24'h00ABCD, 24'h000002, 24'h000005};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset [4];
  logic        start [4];
  logic        abort [4];
  logic        force_done [4];
  logic        force_valid [4];
  logic        eng_done [4] = '{default: 1'b0};
  logic        eng_valid [4] = '{default: 1'b0};
  logic [23:0] key_out [4];
  logic [23:0] found_key [4];
  logic        attempt_start [4];
  logic        busy [4];
  logic        found [4];
  logic        exhausted [4];
  logic [24:0] attempts [4];
  logic [3:0]  hex0 [4];
  logic [3:0]  hex1 [4];
  logic [3:0]  hex2 [4];
  logic [3:0]  hex3 [4];
  logic [3:0]  hex4 [4];
  logic [3:0]  hex5 [4];
  logic [2:0]  state [4];

  int          lat_cfg [4];
  int          vkey [4];
  int          pcnt [4] = '{default: 0};
  int          ecnt [4] = '{default: 0};
  int          epend [4] = '{default: 0};
  logic [23:0] ekey [4];
  logic [23:0] pkeys [4][512];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    key_search_ctrl #(
      .KEY_START(KS[g]),
      .KEY_END  (KE[g])
    ) u_dut (
      .clk          (clk),
      .reset        (reset[g]),
      .start        (start[g]),
      .abort        (abort[g]),
      .attempt_done (eng_done[g] | force_done[g]),
      .attempt_valid(eng_valid[g] | force_valid[g]),
      .key_out      (key_out[g]),
      .attempt_start(attempt_start[g]),
      .busy         (busy[g]),
      .found        (found[g]),
      .exhausted    (exhausted[g]),
      .found_key    (found_key[g]),
      .attempts     (attempts[g]),
      .hex0         (hex0[g]),
      .hex1         (hex1[g]),
      .hex2         (hex2[g]),
      .hex3         (hex3[g]),
      .hex4         (hex4[g]),
      .hex5         (hex5[g]),
      .state        (state[g])
    );
  end

  // Engine model: done (with validity for the launched key) lat cycles after each pulse;
  // also logs every launched key.
  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      eng_done[g]  = 1'b0;
      eng_valid[g] = 1'b0;
      if (epend[g] != 0) begin
        ecnt[g]--;
        if (ecnt[g] == 0) begin
          eng_done[g]  = 1'b1;
          eng_valid[g] = (int'(ekey[g]) == vkey[g]);
          epend[g]     = 0;
        end
      end
      if (attempt_start[g] === 1'b1) begin
        epend[g] = 1;
        ecnt[g]  = (lat_cfg[g] > 0) ? lat_cfg[g] : int'($urandom_range(4, 1));
        ekey[g]  = key_out[g];
        if (pcnt[g] < 512) pkeys[g][pcnt[g]] = key_out[g];
        pcnt[g]++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go(input int g);
    start[g] = 1'b1;
    tick(1);
    start[g] = 1'b0;
  endtask

  task automatic wait_st(input int g, input logic [2:0] st, input int budget, input string tag);
    int n = 0;
    while (state[g] !== st && n < budget) begin
      tick(1);
      n++;
    end
    chk(tag, 32'(state[g]), 32'(st));
  endtask

  task automatic wait_key_st(input int g, input logic [2:0] st, input logic [23:0] k,
                             input int budget, input string tag);
    int n = 0;
    while ((state[g] !== st || key_out[g] !== k) && n < budget) begin
      tick(1);
      n++;
    end
    chk({tag, "_state"}, 32'(state[g]), 32'(st));
    chk({tag, "_key"}, 32'(key_out[g]), 32'(k));
  endtask

  // Expected outcome from the search rules: first valid key in range, else the whole range.
  task automatic check_search(input int g, input int vk, input int base, input string tag);
    int s   = int'(KS[g]);
    int e   = int'(KE[g]);
    bit hit = (vk >= s) && (vk <= e);
    int n   = hit ? (vk - s + 1) : (e - s + 1);
    wait_st(g, hit ? 3'd3 : 3'd4, 20 * n + 50, {tag, "_end"});
    chk({tag, "_attempts"}, 32'(attempts[g]), n);
    chk({tag, "_key_out"}, 32'(key_out[g]), hit ? vk : e);
    chk({tag, "_found_key"}, 32'(found_key[g]), hit ? vk : 0);
    chk({tag, "_found"}, 32'(found[g]), 32'(hit));
    chk({tag, "_exhausted"}, 32'(exhausted[g]), 32'(!hit));
    chk({tag, "_busy"}, 32'(busy[g]), 0);
    chk({tag, "_pulses"}, pcnt[g] - base, n);
    for (int i = 0; i < n; i++) begin
      if (base + i < 512) chk($sformatf("%s_pkey%0d", tag, i), 32'(pkeys[g][base + i]), s + i);
    end
  endtask

  initial begin
    int b;
    int vk;
    for (int g = 0; g < 4; g++) begin
      reset[g]       = 1'b1;
      start[g]       = 1'b0;
      abort[g]       = 1'b0;
      force_done[g]  = 1'b0;
      force_valid[g] = 1'b0;
      lat_cfg[g]     = 3;
      vkey[g]        = -1;
    end
    tick(2);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("rst_state%0d", g), 32'(state[g]), 0);
      chk($sformatf("rst_key%0d", g), 32'(key_out[g]), 32'(KS[g]));
      chk($sformatf("rst_attempts%0d", g), 32'(attempts[g]), 0);
      chk($sformatf("rst_found_key%0d", g), 32'(found_key[g]), 0);
      chk($sformatf("rst_busy%0d", g), 32'(busy[g]), 0);
      chk($sformatf("rst_pulse%0d", g), 32'(attempt_start[g]), 0);
      chk($sformatf("rst_found%0d", g), 32'(found[g]), 0);
      chk($sformatf("rst_exh%0d", g), 32'(exhausted[g]), 0);
      reset[g] = 1'b0;
    end
    tick(1);

    // Keys 0..5, engine done 3 cycles after each pulse, key 3 valid.
    b = pcnt[0];
    lat_cfg[0] = 3;
    vkey[0] = 3;
    go(0);
    chk("launch_pulse", 32'(attempt_start[0]), 1);
    chk("launch_busy", 32'(busy[0]), 1);
    check_search(0, 3, b, "find3");
    tick(5);
    chk("found_hold", 32'(found[0]), 1);

    // Start held through a search, stray valid done injected while launching key 2.
    b = pcnt[0];
    lat_cfg[0] = 2;
    vkey[0] = 5;
    start[0] = 1'b1;
    wait_key_st(0, 3'd1, 24'd2, 200, "stray_launch");
    force_done[0] = 1'b1;
    force_valid[0] = 1'b1;
    tick(1);
    force_done[0] = 1'b0;
    force_valid[0] = 1'b0;
    chk("stray_state", 32'(state[0]), 2);
    chk("stray_attempts", 32'(attempts[0]), 2);
    wait_st(0, 3'd3, 200, "held_start_found");
    start[0] = 1'b0;
    check_search(0, 5, b, "held_start");

    // Abort and done together in WAIT on key 2.
    b = pcnt[0];
    lat_cfg[0] = 3;
    vkey[0] = -1;
    go(0);
    wait_key_st(0, 3'd2, 24'd2, 200, "abort_wait");
    abort[0] = 1'b1;
    force_done[0] = 1'b1;
    force_valid[0] = 1'b1;
    tick(1);
    abort[0] = 1'b0;
    force_done[0] = 1'b0;
    force_valid[0] = 1'b0;
    chk("abort_state", 32'(state[0]), 0);
    chk("abort_attempts", 32'(attempts[0]), 2);
    chk("abort_found", 32'(found[0]), 0);
    chk("abort_key", 32'(key_out[0]), 2);
    chk("abort_busy", 32'(busy[0]), 0);
    tick(6);
    chk("abort_idle_state", 32'(state[0]), 0);
    chk("abort_idle_attempts", 32'(attempts[0]), 2);
    chk("abort_pulses", pcnt[0] - b, 3);

    // Keys 0..2, never valid.
    b = pcnt[1];
    go(1);
    check_search(1, -1, b, "exhaust");
    tick(10);
    chk("exhaust_no_more", pcnt[1] - b, 3);
    chk("exhaust_hold", 32'(exhausted[1]), 1);

    // Single-key range.
    b = pcnt[2];
    vkey[2] = 32'h00ABCD;
    go(2);
    check_search(2, 32'h00ABCD, b, "single");
    chk("hex0", 32'(hex0[2]), 32'hD);
    chk("hex1", 32'(hex1[2]), 32'hC);
    chk("hex2", 32'(hex2[2]), 32'hB);
    chk("hex3", 32'(hex3[2]), 32'hA);
    chk("hex4", 32'(hex4[2]), 0);
    chk("hex5", 32'(hex5[2]), 0);

    // Reset while waiting on key 7.
    b = pcnt[3];
    vkey[3] = -1;
    go(3);
    wait_key_st(3, 3'd2, 24'd7, 200, "rst_mid_wait");
    reset[3] = 1'b1;
    #1;
    chk("rst_mid_busy_during", 32'(busy[3]), 0);
    chk("rst_mid_pulse_during", 32'(attempt_start[3]), 0);
    tick(1);
    reset[3] = 1'b0;
    chk("rst_mid_state", 32'(state[3]), 0);
    chk("rst_mid_key", 32'(key_out[3]), 0);
    chk("rst_mid_attempts", 32'(attempts[3]), 0);
    chk("rst_mid_busy", 32'(busy[3]), 0);
    tick(10);
    chk("rst_mid_pulses", pcnt[3] - b, 8);
    chk("rst_mid_idle", 32'(state[3]), 0);

    // Randomized searches with random engine latency.
    for (int r = 0; r < 4; r++) begin
      vk = int'($urandom_range(7, 0));
      vkey[0] = vk;
      lat_cfg[0] = 0;
      b = pcnt[0];
      go(0);
      check_search(0, vk, b, $sformatf("rnd0_%0d", r));
    end
    for (int r = 0; r < 3; r++) begin
      vk = int'($urandom_range(20, 0));
      vkey[3] = vk;
      lat_cfg[3] = 0;
      b = pcnt[3];
      go(3);
      check_search(3, vk, b, $sformatf("rnd3_%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
